// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave):
// request/grant for addresses, in-order valid/data for responses.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues credit-limited imem requests and
// feeds a 2-entry in-order instruction queue whose head drives the IF/ID register.

module fetch_unit_checker (
    input logic       clk,
    input logic       rst,
    input logic       imem_rvalid,
    input logic [1:0] outstanding
);
    // A response is only legal while some request is still in flight.
    a_rvalid_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (outstanding != 2'd0));
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    fetch_unit_if.master imem,
    output logic [31:0]  instF,
    output logic [31:0]  PCF,
    output logic [31:0]  PCPlus4F,
    output logic         validF
);
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [31:0] fetch_pc_r, fetch_pc_s;
    logic [1:0]  outstanding_r, outstanding_s;
    logic [1:0]  drop_r, drop_s;
    logic [1:0]  occ_r, occ_s, occ_kept_s;
    logic [31:0] q0_inst_r, q0_inst_s, q0_pc_r, q0_pc_s;
    logic [31:0] q1_inst_r, q1_inst_s, q1_pc_r, q1_pc_s;
    logic        valid_r, valid_s;
    logic [31:0] inst_out_r, inst_out_s, pc_out_r, pc_out_s, pc4_out_r, pc4_out_s;
    logic        pop_s, push_s, req_s, gnt_s;
    logic [2:0]  credit_s;
    logic [31:0] resp_pc_s;

    // Handshake decode; a request is only made when its response is guaranteed a queue slot.
    always_comb begin
        pop_s     = valid_r & ~stall & ~redirect;
        credit_s  = {1'b0, outstanding_r} + {1'b0, occ_r} - {2'b00, pop_s};
        req_s     = ~rst & ~redirect & (credit_s < 3'd2);
        gnt_s     = req_s & imem.imem_gnt;
        push_s    = imem.imem_rvalid & (drop_r == 2'd0) & ~redirect;
        resp_pc_s = fetch_pc_r - {28'd0, outstanding_r, 2'b00};
    end

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = fetch_pc_r;

    // PC and in-flight bookkeeping; a redirect turns every in-flight request into a discard.
    always_comb begin
        if (redirect) begin
            fetch_pc_s    = redirect_pc & 32'hFFFF_FFFC;
            outstanding_s = outstanding_r - {1'b0, imem.imem_rvalid};
            drop_s        = outstanding_r - {1'b0, imem.imem_rvalid};
        end else begin
            fetch_pc_s    = gnt_s ? (fetch_pc_r + 32'd4) : fetch_pc_r;
            outstanding_s = outstanding_r + {1'b0, gnt_s} - {1'b0, imem.imem_rvalid};
            if (imem.imem_rvalid && (drop_r != 2'd0)) begin
                drop_s = drop_r - 2'd1;
            end else begin
                drop_s = drop_r;
            end
        end
    end

    // Shift-style queue: slot 0 is the head; a push lands behind whatever survives the pop.
    always_comb begin
        q0_inst_s  = q0_inst_r;
        q0_pc_s    = q0_pc_r;
        q1_inst_s  = q1_inst_r;
        q1_pc_s    = q1_pc_r;
        occ_kept_s = occ_r;
        occ_s      = occ_r;
        if (redirect) begin
            occ_kept_s = 2'd0;
            occ_s      = 2'd0;
        end else begin
            if (pop_s) begin
                q0_inst_s  = q1_inst_r;
                q0_pc_s    = q1_pc_r;
                occ_kept_s = occ_r - 2'd1;
            end else begin
                occ_kept_s = occ_r;
            end
            if (push_s) begin
                if (occ_kept_s == 2'd0) begin
                    q0_inst_s = imem.imem_rdata;
                    q0_pc_s   = resp_pc_s;
                end else begin
                    q1_inst_s = imem.imem_rdata;
                    q1_pc_s   = resp_pc_s;
                end
                occ_s = occ_kept_s + 2'd1;
            end else begin
                occ_s = occ_kept_s;
            end
        end
    end

    // Next IF/ID-facing values taken from the next head, bubble when the queue will be empty.
    always_comb begin
        if (occ_s != 2'd0) begin
            valid_s    = 1'b1;
            inst_out_s = q0_inst_s;
            pc_out_s   = q0_pc_s;
            pc4_out_s  = q0_pc_s + 32'd4;
        end else begin
            valid_s    = 1'b0;
            inst_out_s = NOP_INST;
            pc_out_s   = 32'd0;
            pc4_out_s  = 32'd0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= 2'd0;
            drop_r        <= 2'd0;
            occ_r         <= 2'd0;
            q0_inst_r     <= NOP_INST;
            q0_pc_r       <= 32'd0;
            q1_inst_r     <= NOP_INST;
            q1_pc_r       <= 32'd0;
            valid_r       <= 1'b0;
            inst_out_r    <= NOP_INST;
            pc_out_r      <= 32'd0;
            pc4_out_r     <= 32'd0;
        end else begin
            fetch_pc_r    <= fetch_pc_s;
            outstanding_r <= outstanding_s;
            drop_r        <= drop_s;
            occ_r         <= occ_s;
            q0_inst_r     <= q0_inst_s;
            q0_pc_r       <= q0_pc_s;
            q1_inst_r     <= q1_inst_s;
            q1_pc_r       <= q1_pc_s;
            valid_r       <= valid_s;
            inst_out_r    <= inst_out_s;
            pc_out_r      <= pc_out_s;
            pc4_out_r     <= pc4_out_s;
        end
    end

    assign validF   = valid_r;
    assign instF    = inst_out_r;
    assign PCF      = pc_out_r;
    assign PCPlus4F = pc4_out_r;

    fetch_unit_checker u_checker (
        .clk         (clk),
        .rst         (rst),
        .imem_rvalid (imem.imem_rvalid),
        .outstanding (outstanding_r)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order instruction memory with programmable latency and an
// program-order scoreboard (expected fetch address and expected consumed PC).
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instF, PCF, PCPlus4F;
    logic        validF;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .instF       (instF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .validF      (validF)
    );

    always #5 clk = ~clk;

    mreq_t       mq[$];
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_pc, exp_fetch;
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_inst, o_pc, o_pc4;

    // One clock cycle, entered and left at a falling edge: drive inputs, let the memory
    // answer, sample and score the outputs, then let the rising edge happen.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic g);
        mreq_t m;
        stall         = st;
        redirect      = rd;
        redirect_pc   = rpc;
        bus.imem_gnt  = g;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = m.addr ^ 32'h0000_0100;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
        o_req   = bus.imem_req;
        o_addr  = bus.imem_addr;
        o_valid = validF;
        o_inst  = instF;
        o_pc    = PCF;
        o_pc4   = PCPlus4F;
        n_cmp++;
        if (o_valid === 1'b1) begin
            if (o_inst !== (o_pc ^ 32'h0000_0100) || o_pc4 !== (o_pc + 32'd4)) begin
                n_mis++;
                $display("FAIL head_pair: inst=%h pc=%h pc4=%h, required inst=pc^0x100 pc4=pc+4", o_inst, o_pc, o_pc4);
            end
            if (!st && !rd) begin
                n_cmp++;
                if (o_pc !== exp_pc) begin
                    n_mis++;
                    $display("FAIL order: consumed PCF=%h required %h", o_pc, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
            end
        end else begin
            if (o_valid !== 1'b0 || o_inst !== NOP || o_pc !== 32'd0 || o_pc4 !== 32'd0) begin
                n_mis++;
                $display("FAIL bubble: valid=%b inst=%h pc=%h pc4=%h, required 0/00000013/0/0", o_valid, o_inst, o_pc, o_pc4);
            end
        end
        if (rd) begin
            n_cmp++;
            if (o_req !== 1'b0) begin
                n_mis++;
                $display("FAIL req_in_redirect: imem_req=%b required 0", o_req);
            end
        end
        if (o_req === 1'b1 && g) begin
            n_cmp++;
            if (o_addr !== exp_fetch) begin
                n_mis++;
                $display("FAIL fetch_addr: imem_addr=%h required %h", o_addr, exp_fetch);
            end
            m.addr   = o_addr;
            m.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = m.due;
            mq.push_back(m);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (rd) begin
            exp_fetch = rpc & 32'hFFFF_FFFC;
            exp_pc    = rpc & 32'hFFFF_FFFC;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic release_reset();
        mq.delete();
        last_due  = 0;
        exp_pc    = RESET_PC;
        exp_fetch = RESET_PC;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (validF !== 1'b0 || instF !== NOP || PCF !== 32'd0 || PCPlus4F !== 32'd0 || bus.imem_req !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_values: valid=%b inst=%h pc=%h pc4=%h req=%b", validF, instF, PCF, PCPlus4F, bus.imem_req);
        end
        release_reset();
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        lat = 1;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
            n_cmp++;
            if (o_req !== 1'b1 || o_addr !== 32'(4 * k)) begin
                n_mis++;
                $display("FAIL stream_addr: cycle %0d req=%b addr=%h required 1/%h", k, o_req, o_addr, 32'(4 * k));
            end
            n_cmp++;
            if (k < 2) begin
                if (o_valid !== 1'b0) begin
                    n_mis++;
                    $display("FAIL stream_latency: cycle %0d validF=%b required 0", k, o_valid);
                end
            end else begin
                epc = 32'(4 * (k - 2));
                if (o_valid !== 1'b1 || o_pc !== epc || o_inst !== (epc | 32'h100) || o_pc4 !== epc + 32'd4) begin
                    n_mis++;
                    $display("FAIL stream_out: cycle %0d valid=%b inst=%h pc=%h pc4=%h required pc=%h", k, o_valid, o_inst, o_pc, o_pc4, epc);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc0, inst0;
        pc0 = 32'd0;
        inst0 = 32'd0;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b0, 32'd0, 1'b1);
            if (k == 0) begin
                pc0   = o_pc;
                inst0 = o_inst;
            end else begin
                n_cmp++;
                if (o_valid !== 1'b1 || o_pc !== pc0 || o_inst !== inst0) begin
                    n_mis++;
                    $display("FAIL stall_hold: valid=%b pc=%h inst=%h required 1/%h/%h", o_valid, o_pc, o_inst, pc0, inst0);
                end
                n_cmp++;
                if (o_req !== 1'b0) begin
                    n_mis++;
                    $display("FAIL stall_req: imem_req=%b required 0 with full queue", o_req);
                end
            end
        end
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_redirect_stale();
        bit found, seen_req, seen_valid;
        found = 1'b0;
        seen_req = 1'b0;
        seen_valid = 1'b0;
        lat = 3;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mq.size() == 2 && mq[0].due > cyc) found = 1'b1;
            else cycle(1'b0, 1'b0, 32'd0, 1'b1);
        end
        n_cmp++;
        if (!found) begin
            n_mis++;
            $display("FAIL stale_setup: never saw 2 requests in flight, got %0d", mq.size());
        end else begin
            cycle(1'b0, 1'b1, 32'h0000_0203, 1'b1);
            for (int i = 0; i < 30 && !seen_valid; i++) begin
                cycle(1'b0, 1'b0, 32'd0, 1'b1);
                if (!seen_req && o_req === 1'b1) begin
                    seen_req = 1'b1;
                    n_cmp++;
                    if (o_addr !== 32'h0000_0200) begin
                        n_mis++;
                        $display("FAIL stale_refetch: imem_addr=%h required 00000200", o_addr);
                    end
                end
                if (o_valid === 1'b1) begin
                    seen_valid = 1'b1;
                    n_cmp++;
                    if (o_pc !== 32'h0000_0200 || o_inst !== 32'h0000_0300) begin
                        n_mis++;
                        $display("FAIL stale_first: pc=%h inst=%h required 00000200/00000300", o_pc, o_inst);
                    end
                end
            end
            n_cmp++;
            if (!seen_valid) begin
                n_mis++;
                $display("FAIL stale_timeout: validF=%b after 30 cycles, required 1", o_valid);
            end
        end
    endtask

    task automatic test_redirect_rvalid();
        logic [31:0] tgt, ta;
        lat = 1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
            tgt = $urandom;
            ta  = tgt & 32'hFFFF_FFFC;
            cycle(1'b0, 1'b1, tgt, 1'b1);
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
            n_cmp++;
            if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== ta) begin
                n_mis++;
                $display("FAIL redir_n1: valid=%b req=%b addr=%h required 0/1/%h", o_valid, o_req, o_addr, ta);
            end
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
            n_cmp++;
            if (o_valid !== 1'b0) begin
                n_mis++;
                $display("FAIL redir_n2: validF=%b pc=%h required 0", o_valid, o_pc);
            end
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
            n_cmp++;
            if (o_valid !== 1'b1 || o_pc !== ta || o_inst !== (ta ^ 32'h100)) begin
                n_mis++;
                $display("FAIL redir_n3: valid=%b pc=%h inst=%h required 1/%h/%h", o_valid, o_pc, o_inst, ta, ta ^ 32'h100);
            end
        end
    endtask

    task automatic test_gnt_hold();
        lat = 1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0000_0010, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0);
            n_cmp++;
            if (o_req !== 1'b1 || o_addr !== 32'h0000_0010) begin
                n_mis++;
                $display("FAIL gnt_hold: wait %0d req=%b addr=%h required 1/00000010", i, o_req, o_addr);
            end
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        n_cmp++;
        if (o_req !== 1'b1 || o_addr !== 32'h0000_0010) begin
            n_mis++;
            $display("FAIL gnt_accept: req=%b addr=%h required 1/00000010", o_req, o_addr);
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        n_cmp++;
        if (o_req !== 1'b1 || o_addr !== 32'h0000_0014) begin
            n_mis++;
            $display("FAIL gnt_advance: req=%b addr=%h required 1/00000014", o_req, o_addr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] last;
        bit seen_req, seen_pc;
        last = 32'd0;
        seen_req = 1'b0;
        seen_pc = 1'b0;
        lat = 1;
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
            if (o_req === 1'b1) begin
                if (last == 32'hFFFF_FFFC) begin
                    seen_req = 1'b1;
                    n_cmp++;
                    if (o_addr !== 32'h0000_0000) begin
                        n_mis++;
                        $display("FAIL wrap_addr: imem_addr=%h required 00000000", o_addr);
                    end
                end
                last = o_addr;
            end
            if (o_valid === 1'b1 && o_pc === 32'hFFFF_FFFC) begin
                seen_pc = 1'b1;
                n_cmp++;
                if (o_pc4 !== 32'h0000_0000) begin
                    n_mis++;
                    $display("FAIL wrap_pc4: PCPlus4F=%h required 00000000", o_pc4);
                end
            end
        end
        n_cmp++;
        if (!seen_req || !seen_pc) begin
            n_mis++;
            $display("FAIL wrap_seen: wrap request=%b head at FFFFFFFC=%b, required 1/1", seen_req, seen_pc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 3);
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0);
        end
    endtask

    task automatic test_reset_midrun();
        lat = 3;
        for (int i = 0; i < 6; i++) cycle(i >= 3, 1'b0, 32'd0, 1'b1);
        rst             = 1'b1;
        stall           = 1'b0;
        redirect        = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_gnt    = 1'b1;
        #1;
        n_cmp++;
        if (validF !== 1'b0 || instF !== NOP || PCF !== 32'd0 || PCPlus4F !== 32'd0 || bus.imem_req !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_async: valid=%b inst=%h pc=%h pc4=%h req=%b", validF, instF, PCF, PCPlus4F, bus.imem_req);
        end
        release_reset();
        lat = 1;
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        n_cmp++;
        if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
            n_mis++;
            $display("FAIL reset_restart: req=%b addr=%h required 1/%h", o_req, o_addr, RESET_PC);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        rst             = 1'b1;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'd0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        exp_pc          = RESET_PC;
        exp_fetch       = RESET_PC;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_stale();
        test_redirect_rvalid();
        test_gnt_hold();
        test_wrap();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I pipeline. It owns the program counter and issues word requests to instruction memory over a request/grant/response handshake. Returned instructions go into a 2-entry in-order queue, which feeds instF/PCF/PCPlus4F to the IF/ID pipeline register. The stage honours the decode-stage stall and the execute-stage branch/jump redirect, and presents a NOP bubble whenever no valid instruction is available.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  one clock; reset is asynchronous and active-high
- stall  in  1  IF/ID register holding; head entry must not be consumed
- redirect  in  1  taken branch/jump from execute; flush and refetch
- redirect_pc  in  32  target address; bits [1:0] forced to 0
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  memory accepted request this cycle (sampled only when imem_req=1)
- imem_rvalid  in  1  response data valid; responses in request order, ≥1 cycle after grant
- imem_rdata  in  32  instruction word
- instF  out  32  instruction to IF/ID; 32'h0000_0013 (addi x0,x0,0) when validF=0
- PCF  out  32  address of instF; 0 when validF=0
- PCPlus4F  out  32  PCF+4 (mod 2^32); 0 when validF=0
- validF  out  1  head entry valid

## Operation
- State: fetch_pc (32b), outstanding counter (0..2), drop counter (0..2), queue of 2 entries {inst, pc}, occupancy (0..2).
- Reset values: fetch_pc=RESET_PC, all counters 0, queue empty. Outputs: imem_req=0 while rst=1, validF=0, instF=32'h13, PCF=0, PCPlus4F=0.
- pop = validF & ~stall & ~redirect.
- imem_req = ~rst & ~redirect & (outstanding + occupancy − pop < 2). This credit rule ensures every response has a queue slot.
- imem_addr = fetch_pc. On imem_req & imem_gnt: fetch_pc += 4 (wraps at 2^32), outstanding += 1.
- imem_rvalid handling:
  - If drop > 0: decrement drop and discard the word.
  - Otherwise push {imem_rdata, pc}, where pc is the address of the oldest outstanding request. Track it as fetch_pc − 4·outstanding, or with a small address FIFO.
  - In both cases outstanding decrements.
- Queue is FIFO. Head drives outputs registered (no rdata→instF combinational path). Push and pop may occur in the same cycle, including when occupancy=2 with a pop.
- Redirect (highest priority):
  - Queue flushed, occupancy=0.
  - fetch_pc=redirect_pc & ~3.
  - drop = outstanding − imem_rvalid (all in-flight requests become discards), outstanding = that same value.
  - No request issued in the redirect cycle.
  - redirect with stall in the same cycle: redirect wins, flush still happens.
- imem_req may deassert before grant (redirect); the memory treats an ungranted request as withdrawn.
- While imem_req=1 and not granted, imem_addr holds stable.
- Response with outstanding=0 is a protocol violation. Assert in simulation; RTL behaviour is undefined.
- Reset mid-operation clears all state immediately. Instruction memory shares rst, so no stale responses arrive afterwards.

## Timing
- First request: the first cycle with rst=0, imem_addr=RESET_PC.
- Minimum latency:
  - Grant at cycle N.
  - rvalid at N+1.
  - validF=1 with that instruction at N+2.
- Sustained throughput: 1 instruction/cycle with a 1-cycle memory and stall=0.
- Stall: outputs hold for every stalled cycle. When full, imem_req=0 until the pop.
- Redirect at cycle N:
  - validF=0 at N+1.
  - imem_req=1 with the target at N+1.
  - With a 1-cycle memory, the target instruction reaches validF at N+3.

## Test plan
- Reset release, RESET_PC=0, 1-cycle memory returning addr|0x100, stall=0: expect:
  - imem_addr 0,4,8,… on consecutive cycles
  - validF=1 from cycle 2
  - instF/PCF pairs (0x100,0),(0x104,4),(0x108,8) on consecutive cycles
  - PCPlus4F=PCF+4
- Stall held 3 cycles with queue full: instF/PCF constant, imem_req=0 while stalled, no instruction lost or duplicated after release.
- Redirect to 0x0000_0203 with 2 requests outstanding on a 3-cycle memory: expect:
  - both stale responses discarded
  - next imem_addr=0x200
  - first valid PCF=0x200
  - validF=0 until then, with instF=0x13
- redirect and imem_rvalid in the same cycle: that response is dropped, and the queue holds only post-redirect entries.
- Grant withheld 4 cycles: imem_addr stable at 0x10, imem_req stays 1, then fetch proceeds to 0x14.
- fetch_pc=0xFFFF_FFFC fetched: expect PCPlus4F=0x0000_0000 and next imem_addr=0x0.
- Assert rst while queue is full and requests are outstanding: all outputs return to reset values asynchronously, and fetch restarts at RESET_PC.
